// File: rtl/alu_issue_decode_pkg.sv
// Shared types and encodings for the RV32I decode/issue stage.
// Holds ALU operation codes, RV32I major opcodes, the immediate bundle
// and the packed issue payload handed to the execute stage.
package alu_issue_decode_pkg;

  // ALU operation codes as understood by the downstream 14-op ALU
  localparam logic [3:0] ALU_EQ  = 4'd0;
  localparam logic [3:0] ALU_NE  = 4'd1;
  localparam logic [3:0] ALU_LT  = 4'd2;
  localparam logic [3:0] ALU_GE  = 4'd3;
  localparam logic [3:0] ALU_LTU = 4'd4;
  localparam logic [3:0] ALU_GEU = 4'd5;
  localparam logic [3:0] ALU_ADD = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8;
  localparam logic [3:0] ALU_AND = 4'd9;
  localparam logic [3:0] ALU_SUB = 4'd10;
  localparam logic [3:0] ALU_SLL = 4'd11;
  localparam logic [3:0] ALU_SRL = 4'd12;
  localparam logic [3:0] ALU_SRA = 4'd13;

  // RV32I major opcodes (inInstr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [31:0] i;
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] u;
    logic [31:0] j;
  } imm_t;

  typedef struct packed {
    logic [3:0]  operation;
    logic [31:0] data_in0;
    logic [31:0] data_in1;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        wb_en;
    logic        set_lsb;
    logic        branch;
    logic        jump;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } issue_t;

endpackage

// File: rtl/alu_issue_decode_if.sv
// Handshake bundles around the decode/issue stage.
// req: instruction + PC + register operands from the regfile read stage.
// iss: registered issue payload towards the execute stage.
interface alu_issue_decode_req_if;
  import alu_issue_decode_pkg::*;
  logic        vld;
  logic        rdy;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_dat;
  logic [31:0] rs2_dat;
  modport master (output vld, instr, pc, rs1_dat, rs2_dat, input rdy);
  modport slave  (input vld, instr, pc, rs1_dat, rs2_dat, output rdy);
endinterface

interface alu_issue_decode_iss_if;
  import alu_issue_decode_pkg::*;
  logic   vld;
  logic   rdy;
  issue_t dat;
  modport master (output vld, dat, input rdy);
  modport slave  (input vld, dat, output rdy);
endinterface

// File: rtl/alu_issue_decode_imm_gen.sv
// Combinational RV32I immediate extraction (I/S/B/U/J), all sign-extended
// from instr[31].  Ports: instr (raw word) in, imm (bundle of five forms) out.
// Zero latency, no state.
module alu_issue_decode_imm_gen
  import alu_issue_decode_pkg::*;
(
  input  logic [31:0] instr,
  output imm_t        imm
);

  always_comb begin
    imm.i = {{20{instr[31]}}, instr[31:20]};
    imm.s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm.b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm.u = {instr[31:12], 12'b0};
    imm.j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

endmodule

// File: rtl/alu_issue_decode.sv
// RV32I decode/issue stage: decodes one instruction per cycle into ALU op,
// operands and side-band flags. Latency 1 (registered output). Backpressure:
// SKID_EN=1 adds a skid entry so req.rdy is a pure flop (!skid full);
// SKID_EN=0 uses req.rdy = !out_vld | iss.rdy.
// Ports: clk, rst_n (async active-low), flush (sync kill), req (slave), iss (master).
module alu_issue_decode
  import alu_issue_decode_pkg::*;
#(
  parameter bit SKID_EN = 1'b1,
  parameter bit ILL_WB  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  alu_issue_decode_req_if.slave   req,
  alu_issue_decode_iss_if.master  iss
);

  imm_t        imm;
  issue_t      dec;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        ill;
  logic        wr;
  logic        rd_nz;

  assign opc   = req.instr[6:0];
  assign f3    = req.instr[14:12];
  assign f7    = req.instr[31:25];
  assign rd_nz = |req.instr[11:7];

  alu_issue_decode_imm_gen u_imm_gen (
    .instr (req.instr),
    .imm   (imm)
  );

  always_comb begin
    dec           = '0;
    dec.pc        = req.pc;
    dec.rd        = req.instr[11:7];
    dec.operation = ALU_ADD;
    ill           = 1'b0;
    wr            = 1'b0;
    unique case (opc)
      OPC_OP, OPC_OP_IMM: begin
        wr            = 1'b1;
        dec.data_in0  = req.rs1_dat;
        dec.data_in1  = (opc == OPC_OP) ? req.rs2_dat : imm.i;
        dec.imm       = (opc == OPC_OP) ? 32'd0 : imm.i;
        unique case (f3)
          3'b000: dec.operation = (opc == OPC_OP && f7[5]) ? ALU_SUB : ALU_ADD;
          3'b001: dec.operation = ALU_SLL;
          3'b010: begin dec.operation = ALU_LT;  dec.set_lsb = 1'b1; end
          3'b011: begin dec.operation = ALU_LTU; dec.set_lsb = 1'b1; end
          3'b100: dec.operation = ALU_XOR;
          3'b101: dec.operation = f7[5] ? ALU_SRA : ALU_SRL;
          3'b110: dec.operation = ALU_OR;
          default: dec.operation = ALU_AND;
        endcase
        // Immediate shifts carry a funct7 in imm[11:5]; only the two
        // shift encodings are meaningful there.
        if (opc == OPC_OP_IMM && (f3 == 3'b001 || f3 == 3'b101) &&
            f7 != 7'b0000000 && f7 != 7'b0100000)
          ill = 1'b1;
      end
      OPC_LUI: begin
        wr           = 1'b1;
        dec.data_in1 = imm.u;
        dec.imm      = imm.u;
      end
      OPC_AUIPC: begin
        wr           = 1'b1;
        dec.data_in0 = req.pc;
        dec.data_in1 = imm.u;
        dec.imm      = imm.u;
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU computes the link value; the target offset rides in imm.
        wr           = 1'b1;
        dec.jump     = 1'b1;
        dec.data_in0 = req.pc;
        dec.data_in1 = 32'd4;
        dec.imm      = (opc == OPC_JAL) ? imm.j : imm.i;
      end
      OPC_BRANCH: begin
        dec.branch   = 1'b1;
        dec.data_in0 = req.rs1_dat;
        dec.data_in1 = req.rs2_dat;
        dec.imm      = imm.b;
        unique case (f3)
          3'b000: dec.operation = ALU_EQ;
          3'b001: dec.operation = ALU_NE;
          3'b100: dec.operation = ALU_LT;
          3'b101: dec.operation = ALU_GE;
          3'b110: dec.operation = ALU_LTU;
          3'b111: dec.operation = ALU_GEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        wr           = 1'b1;
        dec.mem_read = 1'b1;
        dec.data_in0 = req.rs1_dat;
        dec.data_in1 = imm.i;
        dec.imm      = imm.i;
      end
      OPC_STORE: begin
        dec.mem_write  = 1'b1;
        dec.data_in0   = req.rs1_dat;
        dec.data_in1   = imm.s;
        dec.imm        = imm.s;
        dec.store_data = req.rs2_dat;
      end
      default: ill = 1'b1;
    endcase
    if (req.instr[1:0] != 2'b11)
      ill = 1'b1;
    if (ill) begin
      dec           = '0;
      dec.pc        = req.pc;
      dec.rd        = req.instr[11:7];
      dec.operation = ALU_ADD;
      dec.illegal   = 1'b1;
      dec.wb_en     = ILL_WB && rd_nz;
    end else begin
      dec.wb_en     = wr && rd_nz;
    end
  end

  issue_t out_q;
  issue_t skid_q;
  logic   out_vld_q;
  logic   skid_vld_q;
  logic   out_free;
  logic   accept;

  assign out_free = !out_vld_q || iss.rdy;
  assign req.rdy  = SKID_EN ? !skid_vld_q : out_free;
  assign accept   = req.vld && req.rdy;
  assign iss.vld  = out_vld_q;
  assign iss.dat  = out_q;

  // The skid slot only fills while the output is stalled and, being full,
  // blocks acceptance; so it never has to be refilled in the same cycle it
  // drains into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (flush) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
    end else if (out_free) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= 1'b0;
      end else begin
        out_vld_q <= accept;
        if (accept)
          out_q <= dec;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_vld_q <= 1'b1;
    end
  end

endmodule
